// File: rtl/seq_adder_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM encoding and op-mode values.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry-in, carry-out and carry into the slice MSB.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s    = sum[CHUNK-1:0];
    assign cout = sum[CHUNK];
    // Carry into the MSB is recovered from the MSB sum bit, valid for any CHUNK including 1.
    assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, LSB first, one done pulse per operation.
//   state | meaning
//   IDLE  | waiting for start; o/ovf hold the previous result
//   RUN   | adding chunk idx; start ignored
//   DONE  | result valid (done=1); start accepted back-to-back
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH:0]   o,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH:0]   o_q;
    logic             ovf_q;

    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic             cout_c, cmsb_c;
    logic             last;

    assign last = (idx_q == IW'(N - 1));

    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) begin
                a_c = a_q[k*CHUNK +: CHUNK];
                b_c = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (carry_q),
        .s    (s_c),
        .cout (cout_c),
        .cmsb (cmsb_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            o_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract is x0 + ~x1 + 1: invert x1 and seed the carry with 1.
                        a_q     <= x0;
                        b_q     <= (sub == OP_SUB) ? ~x1 : x1;
                        carry_q <= (sub == OP_SUB);
                        idx_q   <= '0;
                        o_q     <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx_q == IW'(k)) o_q[k*CHUNK +: CHUNK] <= s_c;
                    end
                    carry_q <= cout_c;
                    if (last) begin
                        o_q[WIDTH] <= cout_c;
                        ovf_q      <= cmsb_c ^ cout_c;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o   = o_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: directed vectors, corner sequences, random ops and exhaustive 4-bit runs.
module tb_seq_adder;
    import seq_adder_pkg::*;

    logic        clk, rst_n, start, sub;
    logic [15:0] x0, x1;
    logic [16:0] o;
    logic        ovf, busy, done;

    logic       start4 [3];
    logic       sub4   [3];
    logic [3:0] x04    [3];
    logic [3:0] x14    [3];
    logic [4:0] o4     [3];
    logic       ovf4   [3];
    logic       busy4  [3];
    logic       done4  [3];

    int tests = 0;
    int fails = 0;

    seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x0(x0), .x1(x1),
        .o(o), .ovf(ovf), .busy(busy), .done(done));

    seq_adder #(.WIDTH(4), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start4[0]), .sub(sub4[0]), .x0(x04[0]), .x1(x14[0]),
        .o(o4[0]), .ovf(ovf4[0]), .busy(busy4[0]), .done(done4[0]));

    seq_adder #(.WIDTH(4), .CHUNK(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .start(start4[1]), .sub(sub4[1]), .x0(x04[1]), .x1(x14[1]),
        .o(o4[1]), .ovf(ovf4[1]), .busy(busy4[1]), .done(done4[1]));

    seq_adder #(.WIDTH(4), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .start(start4[2]), .sub(sub4[2]), .x0(x04[2]), .x1(x14[2]),
        .o(o4[2]), .ovf(ovf4[2]), .busy(busy4[2]), .done(done4[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] eo;
        logic        eovf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input bit s, input int a, input int b,
                                  output int eo, output bit eovf);
        int lim, sa, sb, sr;
        lim = 1 << w;
        sa  = (a >= lim / 2) ? a - lim : a;
        sb  = (b >= lim / 2) ? b - lim : b;
        if (!s) begin
            eo = a + b;
            sr = sa + sb;
        end else begin
            eo = ((a - b + lim) % lim) + ((a >= b) ? lim : 0);
            sr = sa - sb;
        end
        eovf = (sr >= lim / 2) || (sr < -(lim / 2));
    endfunction

    // Called at a negedge. lat = number of negedges after the start-sampling edge at which done
    // is first seen, i.e. the rising edge that samples done high is edge lat after start.
    task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         output logic [16:0] ro, output logic rovf, output int lat, output int bcnt);
        sub = s; x0 = a; x1 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x0 = 16'($urandom); x1 = 16'($urandom); sub = ~s;
        lat = -1; bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        ro = o; rovf = ovf;
        if (busy && done) chk("busy_done_overlap", 1, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic stream4(input int k, input int nch);
        int a, b, n, eo;
        bit s, eovf;
        for (int idx = 0; idx < 512; idx++) begin
            s = idx[8]; a = (idx >> 4) & 15; b = idx & 15;
            x04[k] = 4'(a); x14[k] = 4'(b); sub4[k] = s; start4[k] = 1'b1;
            @(negedge clk);
            start4[k] = 1'b0;
            x04[k] = 4'($urandom); x14[k] = 4'($urandom); sub4[k] = ~s;
            n = 1;
            while (!done4[k] && n < 20) begin
                @(negedge clk);
                n++;
            end
            model(4, s, a, b, eo, eovf);
            chk($sformatf("c%0d_lat_%0d", nch, idx), n, nch + 1);
            chk($sformatf("c%0d_o_%0d", nch, idx), o4[k], eo);
            chk($sformatf("c%0d_ovf_%0d", nch, idx), ovf4[k], eovf);
        end
        @(negedge clk);
        chk($sformatf("c%0d_done_drop", nch), done4[k], 0);
        chk($sformatf("c%0d_idle", nch), busy4[k], 0);
    endtask

    logic [16:0] ro;
    logic        rovf;
    int          lat, bcnt, dcount, dlat, eo;
    bit          eovf;
    logic [15:0] ra, rb;
    logic        rs;
    logic [16:0] got_o;

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; x0 = '0; x1 = '0;
        for (int k = 0; k < 3; k++) begin
            start4[k] = 1'b0; sub4[k] = 1'b0; x04[k] = '0; x14[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_o", o, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{OP_ADD, 16'h00FF, 16'h0001, 17'h00100, 1'b0};
        vecs[1] = '{OP_ADD, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
        vecs[2] = '{OP_ADD, 16'h7FFF, 16'h0001, 17'h08000, 1'b1};
        vecs[3] = '{OP_SUB, 16'h0005, 16'h0007, 17'h0FFFE, 1'b0};
        vecs[4] = '{OP_SUB, 16'h8000, 16'h0001, 17'h17FFF, 1'b1};
        vecs[5] = '{OP_SUB, 16'h1234, 16'h1234, 17'h10000, 1'b0};

        for (int i = 0; i < 6; i++) begin
            run16(vecs[i].s, vecs[i].a, vecs[i].b, ro, rovf, lat, bcnt);
            chk($sformatf("vec%0d_o", i), ro, vecs[i].eo);
            chk($sformatf("vec%0d_ovf", i), rovf, vecs[i].eovf);
            chk($sformatf("vec%0d_lat", i), lat, 5);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
        end
        repeat (3) @(negedge clk);
        chk("hold_o", o, vecs[5].eo);
        chk("hold_ovf", ovf, vecs[5].eovf);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
            run16(rs, ra, rb, ro, rovf, lat, bcnt);
            model(16, rs, int'(ra), int'(rb), eo, eovf);
            chk($sformatf("rnd%0d_o", i), ro, eo);
            chk($sformatf("rnd%0d_ovf", i), rovf, eovf);
        end

        // Second start arrives mid-RUN and must be ignored.
        x0 = 16'h1111; x1 = 16'h2222; sub = OP_ADD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x0 = 16'hFFFF; x1 = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x0 = '0; x1 = '0;
        dcount = 0; dlat = -1; got_o = '0;
        for (int j = 0; j < 12; j++) begin
            if (done) begin
                dcount++;
                got_o = o;
                if (dlat < 0) dlat = j + 3;
            end
            @(negedge clk);
        end
        chk("busy_start_o", got_o, 17'h03333);
        chk("busy_start_dones", dcount, 1);
        chk("busy_start_lat", dlat, 5);

        // Reset in the second RUN cycle aborts the operation.
        x0 = 16'h1234; x1 = 16'h1111; sub = OP_ADD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_o", o, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        dcount = 0;
        for (int j = 0; j < 10; j++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", dcount, 0);
        run16(OP_ADD, 16'h0003, 16'h0004, ro, rovf, lat, bcnt);
        chk("post_abort_o", ro, 17'h00007);
        chk("post_abort_ovf", rovf, 0);
        chk("post_abort_lat", lat, 5);

        stream4(0, 4);
        stream4(1, 2);
        stream4(2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
